// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: runs loads and stores on a valid/ready data port
// and drives the register-file and system-register write strobes.
//
// state | meaning
// IDLE  | accepting a new instruction from the pipeline register every cycle
// REQ   | memory request presented, waiting for memReady
// WAIT  | load accepted, waiting for memRValid
module mem_wb_stage #(
    parameter logic [1:0] SEL_ALU = 2'd0,
    parameter logic [1:0] SEL_MEM = 2'd1,
    parameter logic [1:0] SEL_PC  = 2'd2,
    parameter logic [1:0] SEL_SYS = 2'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  inWrtIndex,
    input  logic        inRegWrEn,
    input  logic [1:0]  inMulSel,
    input  logic [31:0] inAluOut,
    input  logic [31:0] inData1Out,
    input  logic [31:0] inData2Out,
    input  logic [31:0] inPC,
    input  logic [31:0] inSysDataOut,
    input  logic        inIsLoad,
    input  logic        inIsStore,
    input  logic        inIsRSR,
    input  logic        inIsWSR,
    output logic        hold,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memReady,
    input  logic        memRValid,
    input  logic [31:0] memRData,
    output logic        wbEn,
    output logic [3:0]  wbIndex,
    output logic [31:0] wbData,
    output logic        sysWrEn,
    output logic [31:0] sysWrData,
    output logic        alignErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        is_mem;
    logic        misaligned;
    logic [31:0] sel_data;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  idx_q;
    logic        regwr_q;

    logic        wb_en_q;
    logic [3:0]  wb_index_q;
    logic [31:0] wb_data_q;
    logic        sys_wr_en_q;
    logic [31:0] sys_wr_data_q;
    logic        align_err_q;

    assign is_mem     = inIsLoad | inIsStore;
    assign misaligned = (inAluOut[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_mem && !misaligned) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (memReady) begin
                    state_nxt = we_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (memRValid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writeback data for non-memory instructions; SEL_MEM without a load yields 0.
    always_comb begin
        sel_data = 32'd0;
        if (inIsRSR) begin
            sel_data = inSysDataOut;
        end else if (inMulSel == SEL_ALU) begin
            sel_data = inAluOut;
        end else if (inMulSel == SEL_PC) begin
            sel_data = inPC + 32'd4;
        end else if (inMulSel == SEL_SYS) begin
            sel_data = inSysDataOut;
        end else if (inMulSel == SEL_MEM) begin
            sel_data = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            we_q          <= 1'b0;
            idx_q         <= 4'd0;
            regwr_q       <= 1'b0;
            wb_en_q       <= 1'b0;
            wb_index_q    <= 4'd0;
            wb_data_q     <= 32'd0;
            sys_wr_en_q   <= 1'b0;
            sys_wr_data_q <= 32'd0;
            align_err_q   <= 1'b0;
        end else begin
            wb_en_q     <= 1'b0;
            sys_wr_en_q <= 1'b0;
            align_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        if (misaligned) begin
                            align_err_q <= 1'b1;
                        end else begin
                            addr_q  <= inAluOut;
                            wdata_q <= inData2Out;
                            we_q    <= inIsStore;
                            idx_q   <= inWrtIndex;
                            regwr_q <= inRegWrEn;
                        end
                    end else begin
                        wb_en_q       <= inRegWrEn;
                        wb_index_q    <= inWrtIndex;
                        wb_data_q     <= sel_data;
                        sys_wr_en_q   <= inIsWSR;
                        sys_wr_data_q <= inData1Out;
                    end
                end
                WAIT: begin
                    if (memRValid) begin
                        wb_en_q    <= regwr_q;
                        wb_index_q <= idx_q;
                        wb_data_q  <= memRData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hold      = (state != IDLE);
    assign memReq    = (state == REQ);
    assign memWe     = (state == REQ) & we_q;
    assign memAddr   = addr_q;
    assign memWData  = wdata_q;
    assign wbEn      = wb_en_q;
    assign wbIndex   = wb_index_q;
    assign wbData    = wb_data_q;
    assign sysWrEn   = sys_wr_en_q;
    assign sysWrData = sys_wr_data_q;
    assign alignErr  = align_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writebacks are queued when an
// instruction is driven and compared when the stage pulses wbEn / sysWrEn.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  inWrtIndex;
    logic        inRegWrEn;
    logic [1:0]  inMulSel;
    logic [31:0] inAluOut, inData1Out, inData2Out, inPC, inSysDataOut;
    logic        inIsLoad, inIsStore, inIsRSR, inIsWSR;
    logic        hold, memReq, memWe;
    logic [31:0] memAddr, memWData;
    logic        memReady, memRValid;
    logic [31:0] memRData;
    logic        wbEn;
    logic [3:0]  wbIndex;
    logic [31:0] wbData;
    logic        sysWrEn;
    logic [31:0] sysWrData;
    logic        alignErr;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } wb_t;

    wb_t         wb_q[$];
    logic [31:0] sys_q[$];
    wb_t         wb_e;
    logic [31:0] sys_e;
    int          checks   = 0;
    int          failures = 0;
    int          hold_cnt = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .inWrtIndex(inWrtIndex), .inRegWrEn(inRegWrEn), .inMulSel(inMulSel),
        .inAluOut(inAluOut), .inData1Out(inData1Out), .inData2Out(inData2Out),
        .inPC(inPC), .inSysDataOut(inSysDataOut),
        .inIsLoad(inIsLoad), .inIsStore(inIsStore), .inIsRSR(inIsRSR), .inIsWSR(inIsWSR),
        .hold(hold), .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memReady(memReady), .memRValid(memRValid), .memRData(memRData),
        .wbEn(wbEn), .wbIndex(wbIndex), .wbData(wbData),
        .sysWrEn(sysWrEn), .sysWrData(sysWrData), .alignErr(alignErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        inWrtIndex = 4'd0; inRegWrEn = 1'b0; inMulSel = 2'd0;
        inAluOut = 32'd0; inData1Out = 32'd0; inData2Out = 32'd0;
        inPC = 32'd0; inSysDataOut = 32'd0;
        inIsLoad = 1'b0; inIsStore = 1'b0; inIsRSR = 1'b0; inIsWSR = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop expected writebacks at the falling edge.
    always @(negedge clk) begin
        if (hold) hold_cnt++;
        if (wbEn === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_e = wb_q.pop_front();
                check("wb_index", {28'd0, wbIndex}, {28'd0, wb_e.idx});
                check("wb_data", wbData, wb_e.data);
            end
        end
        if (sysWrEn === 1'b1) begin
            if (sys_q.size() == 0) begin
                check("sys_unexpected", 32'd1, 32'd0);
            end else begin
                sys_e = sys_q.pop_front();
                check("sys_data", sysWrData, sys_e);
            end
        end
    end

    task automatic do_op(input logic regwr, input logic [3:0] idx, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] sys,
                         input logic rsr, input logic wsr, input logic [31:0] d1,
                         input logic [31:0] exp_data);
        if (regwr) wb_q.push_back('{idx, exp_data});
        if (wsr) sys_q.push_back(d1);
        inRegWrEn = regwr; inWrtIndex = idx; inMulSel = sel; inAluOut = alu;
        inPC = pc; inSysDataOut = sys; inIsRSR = rsr; inIsWSR = wsr; inData1Out = d1;
        hold_cnt = 0;
        step();
        clear_inputs();
        check("op_hold", {31'd0, hold}, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [3:0] idx, input logic [31:0] rdata,
                           input int ready_dly, input int rvalid_dly);
        inIsLoad = 1'b1; inRegWrEn = 1'b1; inWrtIndex = idx; inAluOut = addr;
        inMulSel = 2'd0; inData2Out = 32'h0BAD_0BAD;
        hold_cnt = 0;
        step();
        clear_inputs();
        for (int i = 0; i < ready_dly; i++) begin
            check("ld_req_wait", {31'd0, memReq}, 32'd1);
            check("ld_addr_wait", memAddr, addr);
            step();
        end
        memReady = 1'b1;
        check("ld_req", {31'd0, memReq}, 32'd1);
        check("ld_we", {31'd0, memWe}, 32'd0);
        check("ld_addr", memAddr, addr);
        step();
        memReady = 1'b0;
        check("ld_req_drop", {31'd0, memReq}, 32'd0);
        for (int i = 1; i < rvalid_dly; i++) step();
        wb_q.push_back('{idx, rdata});
        memRValid = 1'b1; memRData = rdata;
        step();
        memRValid = 1'b0; memRData = 32'd0;
        check("ld_hold_cycles", hold_cnt, ready_dly + 1 + rvalid_dly);
        check("ld_hold_end", {31'd0, hold}, 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int ready_dly);
        inIsStore = 1'b1; inRegWrEn = 1'b1; inWrtIndex = 4'd11; inAluOut = addr; inData2Out = data;
        hold_cnt = 0;
        step();
        clear_inputs();
        for (int i = 0; i < ready_dly; i++) begin
            check("st_wdata_wait", memWData, data);
            step();
        end
        memReady = 1'b1;
        check("st_req", {31'd0, memReq}, 32'd1);
        check("st_we", {31'd0, memWe}, 32'd1);
        check("st_addr", memAddr, addr);
        check("st_wdata", memWData, data);
        step();
        memReady = 1'b0;
        check("st_req_drop", {31'd0, memReq}, 32'd0);
        check("st_hold_cycles", hold_cnt, ready_dly + 1);
    endtask

    task automatic do_misaligned(input logic store, input logic [31:0] addr);
        inIsLoad = ~store; inIsStore = store; inRegWrEn = 1'b1; inWrtIndex = 4'd1; inAluOut = addr;
        step();
        clear_inputs();
        check("mis_align_err", {31'd0, alignErr}, 32'd1);
        check("mis_req", {31'd0, memReq}, 32'd0);
        check("mis_hold", {31'd0, hold}, 32'd0);
        step();
        check("mis_pulse_end", {31'd0, alignErr}, 32'd0);
        check("mis_req_after", {31'd0, memReq}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hold"}, {31'd0, hold}, 32'd0);
        check({tag, "_memReq"}, {31'd0, memReq}, 32'd0);
        check({tag, "_memWe"}, {31'd0, memWe}, 32'd0);
        check({tag, "_memAddr"}, memAddr, 32'd0);
        check({tag, "_memWData"}, memWData, 32'd0);
        check({tag, "_wbEn"}, {31'd0, wbEn}, 32'd0);
        check({tag, "_wbIndex"}, {28'd0, wbIndex}, 32'd0);
        check({tag, "_wbData"}, wbData, 32'd0);
        check({tag, "_sysWrEn"}, {31'd0, sysWrEn}, 32'd0);
        check({tag, "_sysWrData"}, sysWrData, 32'd0);
        check({tag, "_alignErr"}, {31'd0, alignErr}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        memReady = 1'b0; memRValid = 1'b0; memRData = 32'd0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b1;

        do_op(1'b1, 4'd5, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_1234);
        do_op(1'b1, 4'd9, 2'd2, 32'd0, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0000);
        do_op(1'b1, 4'd2, 2'd2, 32'd0, 32'h0000_1000, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_1004);
        do_op(1'b1, 4'd3, 2'd0, 32'h11, 32'd0, 32'h0000_ABCD, 1'b1, 1'b0, 32'd0, 32'h0000_ABCD);
        do_op(1'b1, 4'd4, 2'd1, 32'h99, 32'd0, 32'h77, 1'b0, 1'b0, 32'd0, 32'h0000_0000);
        do_op(1'b1, 4'd6, 2'd3, 32'h1, 32'd0, 32'h5A5A, 1'b0, 1'b0, 32'd0, 32'h0000_5A5A);
        do_op(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h7, 32'd0);
        step();
        check("wsr_one_cycle", {31'd0, sysWrEn}, 32'd0);

        do_load(32'h0000_0100, 4'd12, 32'hDEAD_BEEF, 2, 1);
        do_load(32'h0000_0200, 4'd7, 32'hCAFE_F00D, 0, 1);
        do_op(1'b1, 4'd8, 2'd0, 32'h0000_0042, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0042);
        do_load(32'h0000_0300, 4'd15, 32'h1357_9BDF, 1, 3);

        do_store(32'h0000_0040, 32'h0000_0055, 0);
        do_store(32'h0000_0080, 32'h1234_5678, 2);
        do_misaligned(1'b0, 32'h0000_0042);
        do_misaligned(1'b1, 32'h0000_0081);

        // Reset while WAITing for load data; the late memRValid must be ignored.
        inIsLoad = 1'b1; inRegWrEn = 1'b1; inWrtIndex = 4'd2; inAluOut = 32'h0000_0400;
        step();
        clear_inputs();
        memReady = 1'b1;
        step();
        memReady = 1'b0;
        check("wait_hold", {31'd0, hold}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_all_zero("rst_wait");
        memRValid = 1'b1; memRData = 32'h0000_0BAD;
        step();
        memRValid = 1'b0; memRData = 32'd0;
        check("rst_wait_wbEn", {31'd0, wbEn}, 32'd0);
        check("rst_wait_hold2", {31'd0, hold}, 32'd0);

        // Reset while an instruction is presented in IDLE: no capture.
        inRegWrEn = 1'b1; inWrtIndex = 4'd8; inAluOut = 32'h77; inIsWSR = 1'b1; inData1Out = 32'h9;
        reset = 1'b0;
        step();
        clear_inputs();
        reset = 1'b1;
        check("rst_idle_wbEn", {31'd0, wbEn}, 32'd0);
        check("rst_idle_sysWrEn", {31'd0, sysWrEn}, 32'd0);
        check("rst_idle_wbData", wbData, 32'd0);

        do_op(1'b1, 4'd10, 2'd0, 32'hA5A5_0001, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'hA5A5_0001);
        repeat (3) step();
        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("sys_queue_drained", sys_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage sitting downstream of the execute/memory pipeline register; it consumes the register's `out*` bundle (load/store/RSR/WSR flags, write index, ALU result, store data, PC, system data). It runs load/store transactions on a valid/ready data-memory port with a small FSM and drives the register-file write port and the system-register write strobe. While a memory transaction is outstanding it asserts `hold` back to the pipeline register.

## Interface
- `SEL_ALU`, default 2'd0: `inMulSel` code selecting `inAluOut` as writeback data
- `SEL_MEM`, default 2'd1: code selecting load data (loads always use load data regardless of code)
- `SEL_PC`, default 2'd2: code selecting `inPC + 4`
- `SEL_SYS`, default 2'd3: code selecting `inSysDataOut`
- `clk` in 1: clock; all state updates on rising edge
- `reset` in 1: synchronous, active-low reset
- `inWrtIndex` in 4: destination register index
- `inRegWrEn` in 1: instruction writes the register file
- `inMulSel` in 2: writeback data select
- `inAluOut` in 32: ALU result / memory byte address
- `inData1Out` in 32: WSR source data
- `inData2Out` in 32: store data
- `inPC` in 32: instruction PC
- `inSysDataOut` in 32: system-register read data
- `inIsLoad`, `inIsStore`, `inIsRSR`, `inIsWSR` in 1 each: instruction class flags
- `hold` out 1: upstream must freeze its register and keep its outputs stable
- `memReq` out 1: memory request valid
- `memWe` out 1: 1 = store, 0 = load
- `memAddr` out 32: byte address (word-aligned)
- `memWData` out 32: store data
- `memReady` in 1: responder accepts request this cycle
- `memRValid` in 1: load data valid
- `memRData` in 32: load data
- `wbEn` out 1: register-file write strobe
- `wbIndex` out 4, `wbData` out 32: write index and data
- `sysWrEn` out 1, `sysWrData` out 32: system-register write strobe and data
- `alignErr` out 1: one-cycle misaligned-access pulse

## Operation
- FSM states: IDLE, REQ, WAIT. Reset (`reset`=0 at an edge) -> IDLE; every output 0, internal capture registers 0.
- `hold` = (state != IDLE), combinational. Inputs are sampled only at an edge where state is IDLE; in REQ or WAIT they are ignored.
- IDLE capture, non-memory instruction (`inIsLoad`=`inIsStore`=0): next cycle `wbEn`=`inRegWrEn`, `wbIndex`=`inWrtIndex`. `wbData` follows `inMulSel`; `inIsRSR`=1 forces `inSysDataOut`; `SEL_MEM` without a load gives 0. `sysWrEn`=`inIsWSR`, `sysWrData`=`inData1Out`. State stays IDLE.
- IDLE capture, load or store with `inAluOut[1:0]`!=0: no request, no writeback, `alignErr`=1 for one cycle, stay IDLE.
- IDLE capture, aligned load/store: latch address, store data, index and `inRegWrEn`. Next state REQ with `memReq`=1, `memWe`=`inIsStore`.
- REQ: `memReq`, `memWe`, `memAddr` and `memWData` stay stable until an edge with `memReady`=1. On a store, that edge -> IDLE with `memReq`=0 and no writeback. On a load -> WAIT with `memReq`=0.
- WAIT: at an edge with `memRValid`=1, the next state is IDLE. In the following cycle `wbEn`=latched `inRegWrEn`, `wbData`=`memRData`, `wbIndex`=latched index.
- `memRValid` is ignored outside WAIT. The responder never asserts it in the same cycle as the accepting `memReady`.
- `wbEn`, `sysWrEn` and `alignErr` are single-cycle pulses; they are 0 in any cycle without a fresh capture or completion. `wbData` and `wbIndex` hold their last value.
- `inPC + 4` wraps modulo 2^32.

## Timing
- Non-memory instruction: captured at edge E; `wbEn`/`sysWrEn` are high in cycle E+1; `hold` never rises.
- Load, zero-wait responder: capture at E0; cycle 1 REQ (`memReady`=1); cycle 2 WAIT (`memRValid`=1); `wbEn` in cycle 3. `hold` is high in cycles 1-2.
- Store, zero-wait responder: `hold` is high in one cycle (REQ only).
- `hold` falls in the cycle the load's `wbEn` is high; the next instruction is captured at the end of that cycle.
- Reset mid-transaction: at the reset edge, `memReq` drops, state -> IDLE and `hold` -> 0. A later `memRValid` is ignored.
- Reset while an instruction is presented in IDLE: no capture, no pulse.

## Test plan
- ALU op: `inRegWrEn`=1, `inWrtIndex`=5, `inAluOut`=0x1234, `inMulSel`=0 -> next cycle `wbEn`=1, `wbIndex`=5, `wbData`=0x1234, `hold`=0 throughout.
- JAL-style write: `inMulSel`=2, `inPC`=0xFFFFFFFC -> `wbData`=0x00000000. RSR with `inSysDataOut`=0xABCD -> `wbData`=0xABCD.
- Load at 0x100 with a responder delaying `memReady` 2 cycles and `memRValid` 1 cycle, `memRData`=0xDEADBEEF -> `memAddr` stable for 3 REQ cycles, `hold` high 4 cycles, then `wbEn`=1, `wbData`=0xDEADBEEF, `wbIndex` as latched.
- Store at 0x40, data 0x55 -> `memReq`=1 and `memWe`=1 with `memWData`=0x55; `wbEn` never set. Load at 0x42 -> `alignErr` pulse, `memReq` stays 0.
- WSR with `inData1Out`=0x7 -> `sysWrEn`=1, `sysWrData`=0x7 for exactly one cycle.
- Reset asserted while in WAIT, then `memRValid`=1 -> all outputs 0, no `wbEn`, `hold`=0.
